hex_display_scan: RTL and testbench

//  Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display.

---
 rtl/hex_display_scan_if.sv | 25 ++
 rtl/hex_display_scan.sv | 116 +++++++++++
 tb/tb_hex_display_scan.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_scan_if.sv
// Bus between a display host and the hex_display_scan multiplexer: shadow
// load port on one side, per-slot digit/anode/decimal-point drive on the other.
interface hex_display_scan_if #(
   parameter int NDIG = 4
);
   logic [4*NDIG-1:0] Value;    // digit nibbles, digit 0 rightmost
   logic [NDIG-1:0]   Dots;     // decimal-point request per digit, 1 = lit
   logic              Load;     // 1-cycle strobe into the shadow registers
   logic              Pending;  // shadow holds data not yet on the display
   logic [3:0]        Digit;    // nibble of the current slot
   logic [NDIG-1:0]   Anode;    // active-low digit enables
   logic              Dp;       // active-low decimal point

   // Host side: writes values, watches the scan outputs.
   modport master (
      output Value, Dots, Load,
      input  Pending, Digit, Anode, Dp
   );

   // Scanner side.
   modport slave (
      input  Value, Dots, Load,
      output Pending, Digit, Anode, Dp
   );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed scanner for an NDIG-digit common-anode 7-segment display.
// Loads land in a shadow copy and are committed to the displayed copy only at
// a frame boundary, so a frame never mixes old and new digits. Each slot
// starts with BLANK_CYC cycles of all anodes off to suppress ghosting.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant nonzero nibble unless their decimal point is set).
module hex_display_scan #(
   parameter int NDIG      = 4,      // 1..8
   parameter int PRESCALE  = 50000,  // clk cycles per slot, >= BLANK_CYC+2
   parameter int BLANK_CYC = 16      // guard cycles at slot start
) (
   input  logic              clk,
   input  logic              rst,
   hex_display_scan_if.slave bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [PW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [4*NDIG-1:0] shadow_q, shadow_d;
   logic [4*NDIG-1:0] active_q, active_d;
   logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
   logic [NDIG-1:0]   active_dp_q, active_dp_d;
   logic              pending_q, pending_d;

   logic              slot_end;
   logic              frame_end;
   logic              guard;
   logic              lit;
   logic [NDIG-1:0]   anode;

   assign slot_end  = (presc_q == PW'(PRESCALE - 1));
   assign frame_end = slot_end && (idx_q == IW'(NDIG - 1));
   assign guard     = int'(presc_q) < BLANK_CYC;

   // Next-state logic for the slot timer, shadow load and frame commit.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      presc_d     = slot_end ? '0 : presc_q + PW'(1);
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      shadow_dp_d = shadow_dp_q;
      active_d    = active_q;
      active_dp_d = active_dp_q;
      pending_d   = pending_q;

      if (slot_end) begin
         idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
      end

      // Commit uses the pre-edge shadow, so a Load on the boundary edge
      // waits for the following frame.
      if (frame_end && pending_q) begin
         active_d    = shadow_q;
         active_dp_d = shadow_dp_q;
         pending_d   = 1'b0;
      end

      if (bus.Load) begin
         shadow_d    = bus.Value;
         shadow_dp_d = bus.Dots;
         pending_d   = 1'b1;
      end
   end

   // State registers; reset clears the scan position and both value copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the value copies are plain registers, not a RAM, so resetting them is cheap and guarantees a blank "0" display.
         presc_q     <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         shadow_dp_q <= '0;
         active_q    <= '0;
         active_dp_q <= '0;
         pending_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update from pre-edge values.
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         shadow_dp_q <= shadow_dp_d;
         active_q    <= active_d;
         active_dp_q <= active_dp_d;
         pending_q   <= pending_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [IW-1:0] msd;

   // Locate the most significant nonzero nibble; digit 0 when all are zero.
   always_comb begin
      msd = '0;
      for (int i = 1; i < NDIG; i++) begin
         if (active_q[4*i +: 4] != 4'h0) msd = IW'(i);
      end
   end

   assign lit = (idx_q <= msd) || active_dp_q[idx_q];
`else
   assign lit = 1'b1;
`endif

   // Anode decode: all off during the guard or for a blanked digit.
   always_comb begin
      anode = '1;
      if (!guard && lit) anode[idx_q] = 1'b0;
   end

   assign bus.Anode   = anode;
   assign bus.Digit   = active_q[4*idx_q +: 4];
   assign bus.Dp      = ~(active_dp_q[idx_q] && !guard && lit);
   assign bus.Pending = pending_q;
endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with NDIG=4, PRESCALE=8, BLANK_CYC=2.
// Cycle N is the N-th clock period after reset release; outputs are sampled
// 1 ns after the rising edge that starts the cycle.
module tb_hex_display_scan;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;

   hex_display_scan_if #(.NDIG(4)) bus ();

   hex_display_scan #(
      .NDIG     (4),
      .PRESCALE (8),
      .BLANK_CYC(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] d);
      bus.Value = v;
      bus.Dots  = d;
      bus.Load  = 1'b1;
      step();
      bus.Load  = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.Load = 1'b0;
      bus.Value = '0;
      bus.Dots = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         run_to(c);
         checks++;
         if (bus.Anode !== 4'b1111 || bus.Digit !== 4'h0 || bus.Pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_c%0d: anode=%b digit=%h pending=%b, want 1111 0 0",
                     c, bus.Anode, bus.Digit, bus.Pending);
         end
      end
      run_to(2);
      checks++;
      if (bus.Anode !== 4'b1110 || bus.Dp !== 1'b1) begin
         errors++;
         $display("FAIL reset_c2: anode=%b dp=%b, want 1110 1", bus.Anode, bus.Dp);
      end
      run_to(8);
      checks++;
      if (bus.Anode !== 4'b1111) begin
         errors++;
         $display("FAIL reset_c8_guard: anode=%b, want 1111", bus.Anode);
      end
      run_to(10);
      checks++;
      if (bus.Anode !== 4'b1101) begin
         errors++;
         $display("FAIL reset_c10: anode=%b, want 1101", bus.Anode);
      end
   endtask

   task automatic test_load_commit();
      logic [3:0] exp_d [4];
      logic [3:0] exp_a [4];
      exp_d = '{4'h4, 4'h3, 4'h2, 4'h1};
      exp_a = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      do_reset();
      run_to(5);
      load(16'h1234, 4'b0000);
      while (cyc <= 31) begin
         checks++;
         if (bus.Pending !== 1'b1 || bus.Digit !== 4'h0) begin
            errors++;
            $display("FAIL load_hold_c%0d: pending=%b digit=%h, want 1 0",
                     cyc, bus.Pending, bus.Digit);
         end
         step();
      end
      checks++;
      if (bus.Pending !== 1'b0) begin
         errors++;
         $display("FAIL load_commit_pending: pending=%b, want 0", bus.Pending);
      end
      for (int s = 0; s < 4; s++) begin
         run_to(32 + 8*s + 2);
         checks++;
         if (bus.Digit !== exp_d[s] || bus.Anode !== exp_a[s]) begin
            errors++;
            $display("FAIL load_slot%0d: digit=%h anode=%b, want %h %b",
                     s, bus.Digit, bus.Anode, exp_d[s], exp_a[s]);
         end
      end
   endtask

   task automatic test_last_load_wins();
      logic [3:0] exp_d [4];
      exp_d = '{4'hF, 4'hE, 4'hE, 4'hB};
      do_reset();
      run_to(3);
      load(16'hAAAA, 4'b0000);
      run_to(20);
      load(16'hBEEF, 4'b0000);
      for (int s = 0; s < 4; s++) begin
         run_to(32 + 8*s + 2);
         checks++;
         if (bus.Digit !== exp_d[s]) begin
            errors++;
            $display("FAIL last_wins_slot%0d: digit=%h, want %h", s, bus.Digit, exp_d[s]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_to(5);
      load(16'h1111, 4'b0000);
      run_to(31);
      load(16'h2222, 4'b0000);
      checks++;
      if (bus.Pending !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pending_c32: pending=%b, want 1", bus.Pending);
      end
      run_to(34);
      checks++;
      if (bus.Digit !== 4'h1) begin
         errors++;
         $display("FAIL b2b_old_slot0: digit=%h, want 1", bus.Digit);
      end
      run_to(58);
      checks++;
      if (bus.Digit !== 4'h1 || bus.Pending !== 1'b1) begin
         errors++;
         $display("FAIL b2b_old_slot3: digit=%h pending=%b, want 1 1", bus.Digit, bus.Pending);
      end
      run_to(64);
      checks++;
      if (bus.Pending !== 1'b0) begin
         errors++;
         $display("FAIL b2b_pending_c64: pending=%b, want 0", bus.Pending);
      end
      run_to(66);
      checks++;
      if (bus.Digit !== 4'h2) begin
         errors++;
         $display("FAIL b2b_new_slot0: digit=%h, want 2", bus.Digit);
      end
   endtask

   task automatic test_leading_zero();
      logic [3:0] a_s1_zero, a_s2, a_s3;
`ifdef LEADING_ZERO_BLANK_EN
      a_s2      = 4'b1111;
      a_s3      = 4'b1111;
      a_s1_zero = 4'b1111;
`else
      a_s2      = 4'b1011;
      a_s3      = 4'b0111;
      a_s1_zero = 4'b1101;
`endif
      do_reset();
      run_to(1);
      load(16'h0050, 4'b0000);
      run_to(34);
      checks++;
      if (bus.Anode !== 4'b1110 || bus.Digit !== 4'h0) begin
         errors++;
         $display("FAIL lzb_0050_slot0: anode=%b digit=%h, want 1110 0", bus.Anode, bus.Digit);
      end
      run_to(42);
      checks++;
      if (bus.Anode !== 4'b1101 || bus.Digit !== 4'h5) begin
         errors++;
         $display("FAIL lzb_0050_slot1: anode=%b digit=%h, want 1101 5", bus.Anode, bus.Digit);
      end
      run_to(50);
      checks++;
      if (bus.Anode !== a_s2 || bus.Digit !== 4'h0 || bus.Dp !== 1'b1) begin
         errors++;
         $display("FAIL lzb_0050_slot2: anode=%b digit=%h dp=%b, want %b 0 1",
                  bus.Anode, bus.Digit, bus.Dp, a_s2);
      end
      run_to(58);
      checks++;
      if (bus.Anode !== a_s3) begin
         errors++;
         $display("FAIL lzb_0050_slot3: anode=%b, want %b", bus.Anode, a_s3);
      end
      run_to(60);
      load(16'h0000, 4'b0000);
      run_to(66);
      checks++;
      if (bus.Anode !== 4'b1110) begin
         errors++;
         $display("FAIL lzb_0000_slot0: anode=%b, want 1110", bus.Anode);
      end
      run_to(74);
      checks++;
      if (bus.Anode !== a_s1_zero) begin
         errors++;
         $display("FAIL lzb_0000_slot1: anode=%b, want %b", bus.Anode, a_s1_zero);
      end
      run_to(76);
      load(16'h0000, 4'b1000);
      run_to(106);
      checks++;
      if (bus.Anode !== a_s1_zero) begin
         errors++;
         $display("FAIL lzb_dot_slot1: anode=%b, want %b", bus.Anode, a_s1_zero);
      end
      run_to(120);
      checks++;
      if (bus.Anode !== 4'b1111 || bus.Dp !== 1'b1) begin
         errors++;
         $display("FAIL dot_guard_slot3: anode=%b dp=%b, want 1111 1", bus.Anode, bus.Dp);
      end
      run_to(122);
      checks++;
      if (bus.Anode !== 4'b0111 || bus.Dp !== 1'b0) begin
         errors++;
         $display("FAIL dot_lit_slot3: anode=%b dp=%b, want 0111 0", bus.Anode, bus.Dp);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      run_to(1);
      load(16'h1234, 4'b0000);
      run_to(49);
      load(16'h5678, 4'b0000);
      checks++;
      if (bus.Anode !== 4'b1011 || bus.Digit !== 4'h2 || bus.Pending !== 1'b1) begin
         errors++;
         $display("FAIL arst_before: anode=%b digit=%h pending=%b, want 1011 2 1",
                  bus.Anode, bus.Digit, bus.Pending);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.Anode !== 4'b1111 || bus.Digit !== 4'h0 || bus.Pending !== 1'b0 || bus.Dp !== 1'b1) begin
         errors++;
         $display("FAIL arst_immediate: anode=%b digit=%h pending=%b dp=%b, want 1111 0 0 1",
                  bus.Anode, bus.Digit, bus.Pending, bus.Dp);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      run_to(2);
      checks++;
      if (bus.Anode !== 4'b1110 || bus.Digit !== 4'h0) begin
         errors++;
         $display("FAIL arst_restart_c2: anode=%b digit=%h, want 1110 0", bus.Anode, bus.Digit);
      end
      run_to(34);
      checks++;
      if (bus.Digit !== 4'h0 || bus.Pending !== 1'b0) begin
         errors++;
         $display("FAIL arst_next_frame_slot0: digit=%h pending=%b, want 0 0",
                  bus.Digit, bus.Pending);
      end
      run_to(50);
      checks++;
      if (bus.Digit !== 4'h0 || bus.Anode !== 4'b1011) begin
         errors++;
         $display("FAIL arst_next_frame_slot2: digit=%h anode=%b, want 0 1011",
                  bus.Digit, bus.Anode);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      bus.Load  = 1'b0;
      bus.Value = '0;
      bus.Dots  = '0;
      test_reset();
      test_load_commit();
      test_last_load_wins();
      test_back_to_back();
      test_leading_zero();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
